// File: rtl/broadcast_prefetch_unit_pkg.sv
// Shared types and constants for the broadcast prefetch unit and its in-flight pipe.
package broadcast_prefetch_unit_pkg;

    localparam int INT8_SIZE      = 8;
    localparam int INT32_SIZE     = 32;
    localparam int MAX_ADDR_WIDTH = 32;
    localparam int BPF_WORD_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        DRAIN,
        DONE
    } bpf_state_t;

    // Number of 64-bit SRAM words needed to cover n bytes (ceil(n/8)).
    function automatic logic [INT32_SIZE-1:0] bpf_word_count(input logic [INT32_SIZE-1:0] n);
        return (n + 32'(BPF_WORD_BYTES - 1)) >> 3;
    endfunction

endpackage

// File: rtl/broadcast_prefetch_unit_inflight_pipe.sv
// bpf_inflight_pipe: DEPTH-deep {valid, offset} shift register tracking outstanding SRAM reads.
module bpf_inflight_pipe #(
    parameter int DEPTH = 2,
    parameter int OFF_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [OFF_W-1:0] in_offset,
    output logic             head_valid,
    output logic [OFF_W-1:0] head_offset,
    output logic             pending
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [OFF_W-1:0] offset_q [DEPTH];
    logic [OFF_W-1:0] offset_d [DEPTH];

    always_comb begin
        valid_d[0]  = in_valid;
        offset_d[0] = in_offset;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]  = valid_q[k-1];
            offset_d[k] = offset_q[k-1];
        end
        if (clr) begin
            valid_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                offset_d[k] = '0;
            end
        end
    end

    // Entries still in flight after the head leaves this cycle.
    always_comb begin
        pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            pending = pending | valid_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                offset_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++) begin
                offset_q[k] <= offset_d[k];
            end
        end
    end

    assign head_valid  = valid_q[DEPTH-1];
    assign head_offset = offset_q[DEPTH-1];

endmodule

// File: rtl/broadcast_prefetch_unit.sv
// broadcast_prefetch_unit: clears the broadcast cache and streams ceil(N/8) SRAM words into it.
// Optional macro BCAST_PF_TAIL_MASK_EN zeroes the bytes past N in the final word.
module broadcast_prefetch_unit
    import broadcast_prefetch_unit_pkg::*;
#(
    parameter int SRAM_RD_LAT = 2,
    parameter int CACHE_BYTES = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [MAX_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [INT32_SIZE-1:0]     num_elem_i,
    output logic                      sram_rd_en_o,
    output logic [MAX_ADDR_WIDTH-1:0] sram_addr_o,
    input  logic [8*INT8_SIZE-1:0]    sram_rdata_i,
    output logic                      bc_init_o,
    output logic                      bc_valid_o,
    output logic [MAX_ADDR_WIDTH-1:0] bc_addr_o,
    output logic [8*INT8_SIZE-1:0]    bc_data_o,
    output logic [INT32_SIZE-1:0]     bc_num_elem_o,
    output logic                      busy_o,
    output logic                      ready_o,
    output logic                      err_o
);

    bpf_state_t                state_q, state_d;
    logic [MAX_ADDR_WIDTH-1:0] base_q, base_d;
    logic [INT32_SIZE-1:0]     num_q, num_d;
    logic [INT32_SIZE-1:0]     words_q, words_d;
    logic [INT32_SIZE-1:0]     idx_q, idx_d;
    logic                      rd_en_q, rd_en_d;
    logic [MAX_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      init_q, init_d;
    logic                      busy_q, busy_d;
    logic                      ready_q, ready_d;
    logic                      err_q, err_d;

    logic                      start_accept;
    logic                      num_illegal;
    logic                      head_valid;
    logic [MAX_ADDR_WIDTH-1:0] head_offset;
    logic                      pending;
    logic [8*INT8_SIZE-1:0]    tail_mask;

    assign start_accept = (state_q == IDLE) && start_i;
    assign num_illegal  = (num_elem_i == '0) || (num_elem_i > 32'(CACHE_BYTES));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        num_d   = num_q;
        words_d = words_q;
        idx_d   = idx_q;
        rd_en_d = 1'b0;
        addr_d  = '0;
        init_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    num_d   = num_elem_i;
                    words_d = bpf_word_count(num_elem_i);
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    err_d   = num_illegal;
                    if (num_illegal) begin
                        state_d = DONE;
                    end else begin
                        state_d = CLR;
                        init_d  = 1'b1;
                    end
                end
            end
            CLR: begin
                state_d = ISSUE;
                idx_d   = '0;
                rd_en_d = 1'b1;
                addr_d  = base_q;
            end
            ISSUE: begin
                // idx_q is the word whose strobe is on the port this cycle.
                if (idx_q == words_q - 32'd1) begin
                    state_d = DRAIN;
                end else begin
                    idx_d   = idx_q + 32'd1;
                    rd_en_d = 1'b1;
                    addr_d  = base_q + idx_q + 32'd1;
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = !err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            num_q   <= num_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Pipe is fed from the registered strobe, so its head lines up with the returning SRAM data.
    bpf_inflight_pipe #(
        .DEPTH (SRAM_RD_LAT),
        .OFF_W (MAX_ADDR_WIDTH)
    ) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_accept),
        .in_valid    (rd_en_q),
        .in_offset   ({idx_q[MAX_ADDR_WIDTH-4:0], 3'b000}),
        .head_valid  (head_valid),
        .head_offset (head_offset),
        .pending     (pending)
    );

`ifdef BCAST_PF_TAIL_MASK_EN
    always_comb begin
        tail_mask = '1;
        if ((num_q[2:0] != 3'd0) &&
            (head_offset[MAX_ADDR_WIDTH-1:3] == words_q[MAX_ADDR_WIDTH-4:0] - 29'd1)) begin
            for (int k = 0; k < BPF_WORD_BYTES; k++) begin
                if (3'(k) >= num_q[2:0]) begin
                    tail_mask[8*k +: 8] = 8'h00;
                end
            end
        end
    end
`else
    assign tail_mask = '1;
`endif

    assign sram_rd_en_o  = rd_en_q;
    assign sram_addr_o   = addr_q;
    assign bc_init_o     = init_q;
    assign bc_valid_o    = head_valid;
    assign bc_addr_o     = head_valid ? head_offset : '0;
    assign bc_data_o     = head_valid ? (sram_rdata_i & tail_mask) : '0;
    assign bc_num_elem_o = num_q;
    assign busy_o        = busy_q | start_accept;
    assign ready_o       = ready_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_broadcast_prefetch_unit.sv
// Directed bench for broadcast_prefetch_unit: four instances with SRAM_RD_LAT = 1..4 share one stimulus.
module tb_broadcast_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] num_elem;

    logic        rd_en    [4];
    logic [31:0] sram_addr[4];
    logic [63:0] rdata    [4];
    logic        bc_init  [4];
    logic        bc_valid [4];
    logic [31:0] bc_addr  [4];
    logic [63:0] bc_data  [4];
    logic [31:0] bc_num   [4];
    logic        busy     [4];
    logic        ready    [4];
    logic        err      [4];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // Per-instance observations gathered during one load
    int          init_cnt[4], init_cyc[4], rd_cnt[4], first_rd[4], addr_err[4];
    int          wr_cnt[4], last_wr_cyc[4], wr_err[4], idle_data_err[4];
    int          busy_cnt[4], ready_cyc[4], err_seen[4];
    logic [31:0] last_wr_addr[4];
    logic [31:0] cur_base, cur_n;
    int          cur_w, cur_t;

    // Free-running clock and cycle counter used as the time reference
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Content of SRAM word a, distinct per address
    function automatic logic [63:0] sram_word(input logic [31:0] a);
        return {a ^ 32'h5A5A_C3C3, (~a) + 32'h1234_5678};
    endfunction

    // Expected cache write data for word j of the current load
    function automatic logic [63:0] expBcData(input int j);
        logic [63:0] w;
        w = sram_word(cur_base + 32'(j));
`ifdef BCAST_PF_TAIL_MASK_EN
        if (j == cur_w - 1 && cur_n[2:0] != 3'd0) begin
            for (int k = 0; k < 8; k++) begin
                if (k >= int'(cur_n[2:0])) w[8*k +: 8] = 8'h00;
            end
        end
`endif
        return w;
    endfunction

    // One SRAM model and one DUT per read latency
    generate
        for (genvar g = 0; g < 4; g++) begin : g_lat
            localparam int L = g + 1;
            logic        vpipe[L];
            logic [31:0] apipe[L];

            // SRAM read pipe: data is presented L cycles after the strobe, garbage otherwise
            always @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < L; k++) begin
                        vpipe[k] <= 1'b0;
                        apipe[k] <= 32'h0;
                    end
                end else begin
                    vpipe[0] <= rd_en[g];
                    apipe[0] <= sram_addr[g];
                    for (int k = 1; k < L; k++) begin
                        vpipe[k] <= vpipe[k-1];
                        apipe[k] <= apipe[k-1];
                    end
                end
            end

            assign rdata[g] = vpipe[L-1] ? sram_word(apipe[L-1]) : 64'hDEAD_BEEF_0BAD_F00D;

            broadcast_prefetch_unit #(
                .SRAM_RD_LAT (L),
                .CACHE_BYTES (512)
            ) dut (
                .clk           (clk),
                .rst           (rst),
                .start_i       (start),
                .base_addr_i   (base_addr),
                .num_elem_i    (num_elem),
                .sram_rd_en_o  (rd_en[g]),
                .sram_addr_o   (sram_addr[g]),
                .sram_rdata_i  (rdata[g]),
                .bc_init_o     (bc_init[g]),
                .bc_valid_o    (bc_valid[g]),
                .bc_addr_o     (bc_addr[g]),
                .bc_data_o     (bc_data[g]),
                .bc_num_elem_o (bc_num[g]),
                .busy_o        (busy[g]),
                .ready_o       (ready[g]),
                .err_o         (err[g])
            );
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        for (int g = 0; g < 4; g++) begin
            init_cnt[g] = 0;  init_cyc[g] = -1; rd_cnt[g] = 0;    first_rd[g] = -1;
            addr_err[g] = 0;  wr_cnt[g] = 0;    last_wr_cyc[g] = -1;
            wr_err[g] = 0;    idle_data_err[g] = 0; busy_cnt[g] = 0;
            ready_cyc[g] = -1; err_seen[g] = 0;  last_wr_addr[g] = 32'h0;
        end
    endtask

    // Called once per cycle at the falling edge
    task automatic sampleCycle();
        for (int g = 0; g < 4; g++) begin
            if (bc_init[g]) begin
                init_cnt[g]++;
                init_cyc[g] = cyc;
            end
            if (rd_en[g]) begin
                if (rd_cnt[g] == 0) first_rd[g] = cyc;
                if (sram_addr[g] !== cur_base + 32'(rd_cnt[g])) addr_err[g]++;
                rd_cnt[g]++;
            end
            if (bc_valid[g]) begin
                if (bc_addr[g] !== 32'(wr_cnt[g] * 8)) wr_err[g]++;
                if (bc_data[g] !== expBcData(wr_cnt[g])) wr_err[g]++;
                last_wr_cyc[g]  = cyc;
                last_wr_addr[g] = bc_addr[g];
                wr_cnt[g]++;
            end else if (bc_data[g] !== 64'h0) begin
                idle_data_err[g]++;
            end
            if (busy[g]) busy_cnt[g]++;
            if (cyc > cur_t && ready[g] && ready_cyc[g] < 0) ready_cyc[g] = cyc;
            if (cyc > cur_t && err[g]) err_seen[g] = 1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] n);
        @(posedge clk);
        #2;
        base_addr = b;
        num_elem  = n;
        start     = 1'b1;
        cur_t     = cyc;
    endtask

    // One complete load on all instances, then per-instance checks against hand-derived values
    task automatic runLoad(input string name, input logic [31:0] b, input logic [31:0] n,
                           input int w, input bit illegal, input int dup_at);
        bit done;
        int lat;
        clearMon();
        cur_base = b;
        cur_n    = n;
        cur_w    = w;
        applyStimulus(b, n);
        @(negedge clk);
        sampleCycle();
        @(posedge clk);
        #2 start = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            sampleCycle();
            if (dup_at != 0 && cyc == cur_t + dup_at) begin
                start     = 1'b1;
                base_addr = 32'h0;
                num_elem  = 32'd8;
            end else begin
                start = 1'b0;
            end
            if (!busy[0] && !busy[1] && !busy[2] && !busy[3]) done = 1'b1;
        end
        start = 1'b0;
        checkOutput({name, " finished"}, 64'(done), 64'd1);
        for (int g = 0; g < 4; g++) begin
            lat = g + 1;
            if (!illegal) begin
                checkOutput($sformatf("%s lat%0d init_cnt", name, lat), 64'(init_cnt[g]), 64'd1);
                checkOutput($sformatf("%s lat%0d init_cyc", name, lat), 64'(init_cyc[g]), 64'(cur_t + 1));
                checkOutput($sformatf("%s lat%0d rd_cnt", name, lat), 64'(rd_cnt[g]), 64'(w));
                checkOutput($sformatf("%s lat%0d first_rd", name, lat), 64'(first_rd[g]), 64'(cur_t + 2));
                checkOutput($sformatf("%s lat%0d rd_addr_err", name, lat), 64'(addr_err[g]), 64'd0);
                checkOutput($sformatf("%s lat%0d wr_cnt", name, lat), 64'(wr_cnt[g]), 64'(w));
                checkOutput($sformatf("%s lat%0d last_wr_cyc", name, lat), 64'(last_wr_cyc[g]),
                            64'(cur_t + 1 + w + lat));
                checkOutput($sformatf("%s lat%0d last_wr_addr", name, lat), 64'(last_wr_addr[g]),
                            64'((w - 1) * 8));
                checkOutput($sformatf("%s lat%0d wr_err", name, lat), 64'(wr_err[g]), 64'd0);
                checkOutput($sformatf("%s lat%0d ready_cyc", name, lat), 64'(ready_cyc[g]),
                            64'(cur_t + 3 + w + lat));
                checkOutput($sformatf("%s lat%0d busy_cnt", name, lat), 64'(busy_cnt[g]), 64'(3 + w + lat));
                checkOutput($sformatf("%s lat%0d err_seen", name, lat), 64'(err_seen[g]), 64'd0);
            end else begin
                checkOutput($sformatf("%s lat%0d init_cnt", name, lat), 64'(init_cnt[g]), 64'd0);
                checkOutput($sformatf("%s lat%0d rd_cnt", name, lat), 64'(rd_cnt[g]), 64'd0);
                checkOutput($sformatf("%s lat%0d wr_cnt", name, lat), 64'(wr_cnt[g]), 64'd0);
                checkOutput($sformatf("%s lat%0d busy_cnt", name, lat), 64'(busy_cnt[g]), 64'd2);
                checkOutput($sformatf("%s lat%0d ready_seen", name, lat), 64'(ready_cyc[g] >= 0), 64'd0);
                checkOutput($sformatf("%s lat%0d err_o", name, lat), 64'(err[g]), 64'd1);
            end
            checkOutput($sformatf("%s lat%0d idle_data", name, lat), 64'(idle_data_err[g]), 64'd0);
            checkOutput($sformatf("%s lat%0d bc_num", name, lat), 64'(bc_num[g]), 64'(n));
        end
    endtask

    // Reset two cycles after the second strobe of an N=64 load and watch for stray writes
    task automatic runResetMidLoad();
        int stray[4];
        clearMon();
        cur_base = 32'h300;
        cur_n    = 32'd64;
        cur_w    = 8;
        applyStimulus(32'h300, 32'd64);
        @(posedge clk);
        #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int g = 0; g < 4; g++) stray[g] = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (bc_valid[g] || rd_en[g] || busy[g] || bc_init[g]) stray[g]++;
            end
        end
        for (int g = 0; g < 4; g++) begin
            checkOutput($sformatf("rstmid lat%0d stray_activity", g + 1), 64'(stray[g]), 64'd0);
            checkOutput($sformatf("rstmid lat%0d ready_o", g + 1), 64'(ready[g]), 64'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 32'h0;
        num_elem  = 32'h0;
        cur_t     = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checkOutput($sformatf("reset lat%0d rd_en", g + 1), 64'(rd_en[g]), 64'd0);
            checkOutput($sformatf("reset lat%0d bc_valid", g + 1), 64'(bc_valid[g]), 64'd0);
            checkOutput($sformatf("reset lat%0d bc_init", g + 1), 64'(bc_init[g]), 64'd0);
            checkOutput($sformatf("reset lat%0d busy", g + 1), 64'(busy[g]), 64'd0);
            checkOutput($sformatf("reset lat%0d ready", g + 1), 64'(ready[g]), 64'd0);
            checkOutput($sformatf("reset lat%0d err", g + 1), 64'(err[g]), 64'd0);
            checkOutput($sformatf("reset lat%0d bc_data", g + 1), bc_data[g], 64'd0);
            checkOutput($sformatf("reset lat%0d bc_num", g + 1), 64'(bc_num[g]), 64'd0);
        end
        @(posedge clk);
        #2 rst = 1'b0;

        $display("[TB] N=20 base=0x100");
        runLoad("n20", 32'h100, 32'd20, 3, 1'b0, 0);
        $display("[TB] N=1");
        runLoad("n1", 32'h2000, 32'd1, 1, 1'b0, 0);
        $display("[TB] N=0 and N=513");
        runLoad("n0", 32'h40, 32'd0, 0, 1'b1, 0);
        runLoad("n513", 32'h40, 32'd513, 0, 1'b1, 0);
        $display("[TB] N=512 with wrapping base and a start while busy");
        runLoad("n512", 32'hFFFF_FFF0, 32'd512, 64, 1'b0, 10);
        $display("[TB] reset during N=64 load, then N=8");
        runResetMidLoad();
        runLoad("post_rst", 32'h500, 32'd8, 1, 1'b0, 0);
        $display("[TB] N=17 across all latencies");
        runLoad("n17", 32'h40, 32'd17, 3, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
